// File: rtl/kmi_rx_fifo_if.sv
// rtl/kmi_rx_fifo_if.sv - PS/2 pin, read-port and status bundle for kmi_rx_fifo
interface kmi_rx_fifo_if #(
    parameter int DEPTH = 8
);
    logic                     kmiclkin;
    logic                     kmidatain;
    logic                     enable;
    logic                     rd_en;
    logic                     clr_err;
    logic [7:0]               rd_data;
    logic                     rd_err;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     frame_err;
    logic                     busy;
    logic                     kmiintr;

    modport slave (
        input  kmiclkin, kmidatain, enable, rd_en, clr_err,
        output rd_data, rd_err, empty, full, count, overflow, frame_err, busy, kmiintr
    );

    modport master (
        output kmiclkin, kmidatain, enable, rd_en, clr_err,
        input  rd_data, rd_err, empty, full, count, overflow, frame_err, busy, kmiintr
    );
endinterface

// File: rtl/kmi_rx_fifo.sv
// rtl/kmi_rx_fifo.sv - PS/2 receive engine with buffered byte queue
module kmi_rx_fifo #(
    parameter int DEPTH     = 8,
    parameter int SYNC      = 2,
    parameter int TIMEOUT   = 2000,
    parameter int IRQ_LEVEL = 1
) (
    input  logic          ref_clk,
    input  logic          rst,
    kmi_rx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC-1:0] r_clk_sync;
    logic [SYNC-1:0] r_dat_sync;
    logic            r_clk_prev;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_perr;
    logic [TW-1:0]   r_tocnt;
    logic [8:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic            r_frame_err;

    logic w_fe, w_data;
    logic w_shift_en, w_perr_en, w_bit_clr, w_frame_ok, w_stop_bad, w_timeout;
    logic w_full, w_empty, w_push, w_pop, w_ovf_set, w_ferr_set;
    logic [8:0] w_head;

    // Chains reset to the idle-high line level so releasing reset never fakes an edge.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC-2:0], bus.kmiclkin};
            r_dat_sync <= {r_dat_sync[SYNC-2:0], bus.kmidatain};
            r_clk_prev <= r_clk_sync[SYNC-1];
        end
    end

    assign w_fe   = ~r_clk_sync[SYNC-1] & r_clk_prev;
    assign w_data = r_dat_sync[SYNC-1];

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_perr_en   = 1'b0;
        w_bit_clr   = 1'b0;
        w_frame_ok  = 1'b0;
        w_stop_bad  = 1'b0;
        w_timeout   = 1'b0;
        if (!bus.enable) begin
            w_state_nxt = S_IDLE;
        end else if (r_state != S_IDLE && r_tocnt == TO_LAST) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_IDLE;
        end else if (w_fe) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_data) begin
                        w_state_nxt = S_DATA;
                        w_bit_clr   = 1'b1;
                    end
                end
                S_DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
                end
                S_PARITY: begin
                    w_perr_en   = 1'b1;
                    w_state_nxt = S_STOP;
                end
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    w_frame_ok  = w_data;
                    w_stop_bad  = ~w_data;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_perr   <= 1'b0;
        end else begin
            if (w_bit_clr) r_bitcnt <= '0;
            if (w_shift_en) begin
                r_shift  <= {w_data, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_perr_en) r_perr <= ~(^r_shift ^ w_data);
        end
    end

    // Saturating gap counter; idle keeps it cleared so each frame starts fresh.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst)                           r_tocnt <= '0;
        else if (w_fe || r_state == S_IDLE) r_tocnt <= '0;
        else if (r_tocnt != TO_LAST)        r_tocnt <= r_tocnt + TW'(1);
    end

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_pop      = bus.rd_en & ~w_empty;
    assign w_push     = w_frame_ok & (~w_full | w_pop);
    assign w_ovf_set  = w_frame_ok & w_full & ~w_pop;
    assign w_ferr_set = w_stop_bad | w_timeout;

    always_ff @(posedge ref_clk) begin
        if (w_push) r_mem[r_wptr] <= {r_perr, r_shift};
    end

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovf_set)        r_overflow <= 1'b1;
            else if (bus.clr_err) r_overflow <= 1'b0;
            if (w_ferr_set)       r_frame_err <= 1'b1;
            else if (bus.clr_err) r_frame_err <= 1'b0;
        end
    end

    assign w_head        = r_mem[r_rptr];
    assign bus.rd_data   = w_empty ? 8'h00 : w_head[7:0];
    assign bus.rd_err    = w_empty ? 1'b0 : w_head[8];
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.kmiintr   = (r_count >= CW'(IRQ_LEVEL)) | r_overflow | r_frame_err;
endmodule

// File: tb/tb_kmi_rx_fifo.sv
// tb/tb_kmi_rx_fifo.sv - directed vector bench for kmi_rx_fifo
module tb_kmi_rx_fifo;
    localparam int DEPTH     = 4;
    localparam int SYNC      = 2;
    localparam int TIMEOUT   = 100;
    localparam int IRQ_LEVEL = 1;

    logic ref_clk = 1'b0;
    logic rst;
    always #5 ref_clk = ~ref_clk;

    kmi_rx_fifo_if #(.DEPTH(DEPTH)) bus();

    kmi_rx_fifo #(
        .DEPTH(DEPTH), .SYNC(SYNC), .TIMEOUT(TIMEOUT), .IRQ_LEVEL(IRQ_LEVEL)
    ) dut (
        .ref_clk(ref_clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         exp_count;
        logic [7:0] exp_data;
        logic       exp_err;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b, input bit pop_here);
        @(negedge ref_clk);
        bus.kmidatain = b;
        repeat (4) @(negedge ref_clk);
        bus.kmiclkin = 1'b0;
        if (pop_here) begin
            repeat (SYNC) @(posedge ref_clk);
            @(negedge ref_clk);
            bus.rd_en = 1'b1;
            @(negedge ref_clk);
            bus.rd_en = 1'b0;
            repeat (6) @(negedge ref_clk);
        end else begin
            repeat (8) @(negedge ref_clk);
        end
        bus.kmiclkin = 1'b1;
        repeat (4) @(negedge ref_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int nbits, input bit pop_at_stop);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++)
            ps2_bit(bits[i], pop_at_stop && (i == 10));
        bus.kmidatain = 1'b1;
    endtask

    task automatic pop1();
        @(negedge ref_clk);
        bus.rd_en = 1'b1;
        @(negedge ref_clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic clr1();
        @(negedge ref_clk);
        bus.clr_err = 1'b1;
        @(negedge ref_clk);
        bus.clr_err = 1'b0;
    endtask

    initial begin
        logic [7:0] d8;
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 1, 8'h3C, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 1, 8'h80, 1'b1, 1'b0};

        rst = 1'b1;
        bus.kmiclkin  = 1'b1;
        bus.kmidatain = 1'b1;
        bus.enable    = 1'b1;
        bus.rd_en     = 1'b0;
        bus.clr_err   = 1'b0;
        repeat (3) @(negedge ref_clk);
        rst = 1'b0;
        repeat (2) @(negedge ref_clk);
        chk("reset count", bus.count, 0);
        chk("reset empty", bus.empty, 1);
        chk("reset full", bus.full, 0);
        chk("reset rd_data", bus.rd_data, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset kmiintr", bus.kmiintr, 0);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 11, 1'b0);
            repeat (2) @(negedge ref_clk);
            chk($sformatf("vec%0d count", i), bus.count, vecs[i].exp_count);
            chk($sformatf("vec%0d rd_data", i), bus.rd_data, vecs[i].exp_data);
            chk($sformatf("vec%0d rd_err", i), bus.rd_err, vecs[i].exp_err);
            chk($sformatf("vec%0d frame_err", i), bus.frame_err, vecs[i].exp_ferr);
            chk($sformatf("vec%0d kmiintr", i), bus.kmiintr,
                (vecs[i].exp_count >= IRQ_LEVEL) || vecs[i].exp_ferr);
            if (vecs[i].exp_count != 0) begin
                pop1();
                chk($sformatf("vec%0d empty after pop", i), bus.empty, 1);
            end
            clr1();
            chk($sformatf("vec%0d kmiintr idle", i), bus.kmiintr, 0);
        end

        for (int k = 1; k <= 5; k++) begin
            d8 = 8'(k);
            send_frame(d8, ~^d8, 1'b1, 11, 1'b0);
        end
        repeat (2) @(negedge ref_clk);
        chk("ovf full", bus.full, 1);
        chk("ovf overflow", bus.overflow, 1);
        chk("ovf count", bus.count, 4);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf pop%0d data", k), bus.rd_data, k);
            pop1();
        end
        chk("ovf drained empty", bus.empty, 1);
        chk("ovf drained rd_data", bus.rd_data, 0);
        clr1();
        chk("ovf cleared", bus.overflow, 0);

        send_frame(8'h00, 1'b0, 1'b1, 4, 1'b0);
        chk("to busy mid", bus.busy, 1);
        repeat (TIMEOUT + 10) @(negedge ref_clk);
        chk("to busy fell", bus.busy, 0);
        chk("to frame_err", bus.frame_err, 1);
        chk("to count", bus.count, 0);
        clr1();
        send_frame(8'h55, 1'b1, 1'b1, 11, 1'b0);
        repeat (2) @(negedge ref_clk);
        chk("to next data", bus.rd_data, 8'h55);
        chk("to next rd_err", bus.rd_err, 0);
        chk("to next frame_err", bus.frame_err, 0);
        pop1();

        for (int k = 0; k < 4; k++) begin
            d8 = 8'h10 + 8'(k);
            send_frame(d8, ~^d8, 1'b1, 11, 1'b0);
        end
        repeat (2) @(negedge ref_clk);
        chk("fullpop pre count", bus.count, 4);
        send_frame(8'h14, ~^8'h14, 1'b1, 11, 1'b1);
        repeat (2) @(negedge ref_clk);
        chk("fullpop count", bus.count, 4);
        chk("fullpop overflow", bus.overflow, 0);
        chk("fullpop full", bus.full, 1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("fullpop pop%0d data", k), bus.rd_data, 8'h10 + k);
            pop1();
        end
        chk("fullpop drained", bus.empty, 1);

        bus.enable = 1'b0;
        send_frame(8'h22, 1'b1, 1'b1, 11, 1'b0);
        repeat (2) @(negedge ref_clk);
        chk("disabled count", bus.count, 0);
        chk("disabled busy", bus.busy, 0);
        chk("disabled frame_err", bus.frame_err, 0);
        bus.enable = 1'b1;

        send_frame(8'h77, ~^8'h77, 1'b1, 11, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1, 5, 1'b0);
        chk("rstmid busy", bus.busy, 1);
        chk("rstmid pre count", bus.count, 1);
        @(negedge ref_clk);
        rst = 1'b1;
        repeat (2) @(negedge ref_clk);
        rst = 1'b0;
        @(negedge ref_clk);
        chk("rstmid count", bus.count, 0);
        chk("rstmid empty", bus.empty, 1);
        chk("rstmid full", bus.full, 0);
        chk("rstmid rd_data", bus.rd_data, 0);
        chk("rstmid rd_err", bus.rd_err, 0);
        chk("rstmid overflow", bus.overflow, 0);
        chk("rstmid frame_err", bus.frame_err, 0);
        chk("rstmid busy", bus.busy, 0);
        chk("rstmid kmiintr", bus.kmiintr, 0);
        send_frame(8'h6B, ~^8'h6B, 1'b1, 11, 1'b0);
        repeat (2) @(negedge ref_clk);
        chk("rstmid next data", bus.rd_data, 8'h6B);
        chk("rstmid next rd_err", bus.rd_err, 0);
        chk("rstmid next count", bus.count, 1);
        chk("rstmid next kmiintr", bus.kmiintr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
